controle_varredura_demux: RTL and testbench
===========================================

// Module: controle_varredura_demux
// PURPOSE
// - Sweep scheduler for the 8-way position demux. Steps SEL through positions 0..7..0 (ping-pong).
// - At each position it waits a settle time, issues a one-cycle measure request and waits for
//   pronto_medida, with a timeout. It then advances to the next position.
// - Publishes the current angle as 3-digit BCD on s_angulo for display. Sits between top-level
//   control (ligar) and the demux/sensor datapath.
// PARAMETERS
// - BITS           3     width of demux data word dado_demux; must be >= 3
// - SETTLE_CYCLES  1000  clock cycles held in POSICIONA before each request; >= 1
// - TIMEOUT_CYCLES 2000  max cycles in ESPERA before forced advance; >= 1
// PORTS
// - clock           in   1     system clock, rising edge
// - reset           in   1     asynchronous, active-high; clears all state
// - ligar           in   1     level: 1 = run sweep, 0 = stop after current position
// - pronto_medida   in   1     measurement done; sampled only in ESPERA
// - sel             out  3     demux select = current position 0..7
// - dado_demux      out  BITS  demux IN word = position index, zero-extended
// - mede            out  1     one-cycle measure request
// - s_angulo        out  12    BCD angle {hundreds,tens,units}
// - ativo           out  1     1 in any state except INICIAL
// - erro_timeout    out  1     one-cycle pulse when ESPERA expires
// - fim_varredura   out  1     one-cycle pulse on direction reversal at pos 7 or pos 0
// - db_estado       out  4     FSM state code for debug
// BEHAVIOUR
// - Reset (async): state INICIAL; pos=0; dir=up; counter=0; s_angulo=12'h020.
//   All other outputs are 0.
// - Angle map: angle = 20 + 20*pos degrees (pos 0 -> 020, pos 7 -> 160).
//   s_angulo is registered and updated on the same edge that pos changes.
// - States and codes:
//   INICIAL(0) POSICIONA(1) MEDE(2) ESPERA(3) REGISTRA(4) PROXIMO(5).
// - INICIAL: ligar=1 at edge k -> POSICIONA and counter clears. pos is kept from the last run.
// - POSICIONA: counter counts 0..SETTLE_CYCLES-1, then -> MEDE.
//   mede is high exactly at cycle k+SETTLE_CYCLES+1.
// - MEDE: single cycle; mede=1 (Moore output); -> ESPERA with counter cleared.
//   pronto_medida in this cycle is ignored.
// - ESPERA:
//   - pronto_medida=1 -> REGISTRA.
//   - Else when counter reaches TIMEOUT_CYCLES-1 -> REGISTRA, with erro_timeout=1 on that transition.
//   - pronto and expiry in the same cycle: pronto wins, no error pulse.
// - REGISTRA: single cycle, reserved for the datapath to latch the result; -> PROXIMO.
// - PROXIMO: single cycle; updates pos/dir:
//   - up & pos<7: pos+1. up & pos=7: dir=down, pos=6, fim_varredura=1.
//   - down & pos>0: pos-1. down & pos=0: dir=up, pos=1, fim_varredura=1.
//   - Then ligar=1 -> POSICIONA; ligar=0 -> INICIAL.
// - ligar falling mid-position: the current measurement still completes (no truncation).
//   The block stops in INICIAL after PROXIMO.
// - sel and dado_demux change only in PROXIMO and are stable through POSICIONA..REGISTRA.
// - reset mid-operation: immediate return to reset values; no pending pulse survives.
// - Counter width = $clog2(max(SETTLE_CYCLES,TIMEOUT_CYCLES)+1); the counter never wraps.
// STRUCTURE
// - Shared package varredura_pkg holds:
//   - state enum/localparams and their codes;
//   - ANGLE_BCD[0:7] table {020,040,060,080,100,120,140,160};
//   - N_POS=8.
// - One sub-module: contador_m (parametrised up-counter with clear, enable and fim flag).
//   It is reused for both settle and timeout.
// - FSM, pos/dir register and BCD lookup live in this module.
//   The demux itself is instantiated outside, at top level.
// TESTING
// - Reset then ligar=1, SETTLE=4:
//   mede is first high exactly 5 cycles after the ligar edge; sel=0, s_angulo=12'h020.
// - pronto 3 cycles after each mede, 16 positions:
//   sel sequence 0,1..7,6..0,1; fim_varredura pulses after pos 7 and after pos 0.
//   s_angulo at pos 7 = 12'h160.
// - No pronto, TIMEOUT=5: erro_timeout pulses once, 5 cycles after ESPERA entry; sel advances to 1.
// - pronto asserted on the exact expiry cycle: no erro_timeout, normal advance.
//   pronto held high during MEDE only: ignored, timeout occurs.
// - ligar dropped during POSICIONA at pos 3: mede still issued and pronto accepted.
//   Block ends in INICIAL with sel=4, ativo=0. Re-raising ligar resumes at pos 4.
// - reset pulse during ESPERA at pos 5: outputs immediately 0, sel=0, s_angulo=12'h020, db_estado=0.

Source files
------------

// File: rtl/varredura_pkg.sv
// Shared definitions for the position sweep scheduler: FSM state codes,
// angle lookup table and small constant helpers.
package varredura_pkg;

    localparam int N_POS = 8;

    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        POSICIONA = 4'd1,
        MEDE      = 4'd2,
        ESPERA    = 4'd3,
        REGISTRA  = 4'd4,
        PROXIMO   = 4'd5
    } estado_t;

    // Angle per position in BCD: 20 + 20*pos degrees
    localparam logic [11:0] ANGLE_BCD [0:N_POS-1] = '{
        12'h020, 12'h040, 12'h060, 12'h080,
        12'h100, 12'h120, 12'h140, 12'h160
    };

    function automatic logic [11:0] angulo_bcd(input logic [2:0] pos);
        return ANGLE_BCD[pos];
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/controle_varredura_demux_contador.sv
// Saturating up-counter with synchronous clear, enable and a terminal flag
// that is raised once the count has reached a runtime-selected limit.
module contador_m #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limite,
    output logic         o_fim
);

    logic [W-1:0] r_count;

    // Count up while enabled; holds at all-ones so it can never wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_fim = (r_count >= i_limite);

endmodule

// File: rtl/controle_varredura_demux.sv
// Ping-pong sweep scheduler for the 8-way demux: settle, request a measurement,
// wait for completion or timeout, then step to the next position.
module controle_varredura_demux
    import varredura_pkg::*;
#(
    parameter int BITS           = 3,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ligar,
    input  logic            pronto_medida,
    output logic [2:0]      sel,
    output logic [BITS-1:0] dado_demux,
    output logic            mede,
    output logic [11:0]     s_angulo,
    output logic            ativo,
    output logic            erro_timeout,
    output logic            fim_varredura,
    output logic [3:0]      db_estado
);

    localparam int CW = $clog2(max_int(SETTLE_CYCLES, TIMEOUT_CYCLES) + 1);

    estado_t     r_estado;
    logic [2:0]  r_pos;
    logic        r_desce;
    logic [11:0] r_angulo;
    logic        r_mede;
    logic        r_ativo;
    logic        r_erro;
    logic        r_fim;

    logic          w_clr;
    logic          w_en;
    logic          w_fim;
    logic [CW-1:0] w_limite;
    logic [2:0]    w_pos_prox;
    logic          w_desce_prox;
    logic          w_vira;

    // Counter control: restart on entry to each timed state, run while timing
    always_comb begin
        w_clr    = 1'b0;
        w_en     = 1'b0;
        w_limite = CW'(SETTLE_CYCLES);
        case (r_estado)
            INICIAL, MEDE, PROXIMO: w_clr = 1'b1;
            POSICIONA:              w_en  = 1'b1;
            ESPERA: begin
                w_en     = 1'b1;
                w_limite = CW'(TIMEOUT_CYCLES - 1);
            end
            default: w_clr = 1'b1;
        endcase
    end

    contador_m #(.W(CW)) u_contador (
        .clk      (clock),
        .rst      (reset),
        .i_clr    (w_clr),
        .i_en     (w_en),
        .i_limite (w_limite),
        .o_fim    (w_fim)
    );

    // Next position of the ping-pong walk; reversal bounces off the ends
    always_comb begin
        w_pos_prox   = r_pos;
        w_desce_prox = r_desce;
        w_vira       = 1'b0;
        if (!r_desce) begin
            if (r_pos == 3'd7) begin
                w_pos_prox   = 3'd6;
                w_desce_prox = 1'b1;
                w_vira       = 1'b1;
            end else begin
                w_pos_prox = r_pos + 3'd1;
            end
        end else begin
            if (r_pos == 3'd0) begin
                w_pos_prox   = 3'd1;
                w_desce_prox = 1'b0;
                w_vira       = 1'b1;
            end else begin
                w_pos_prox = r_pos - 3'd1;
            end
        end
    end

    // Sweep FSM with registered Moore outputs and single-cycle pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado <= INICIAL;
            r_pos    <= 3'd0;
            r_desce  <= 1'b0;
            r_angulo <= 12'h020;
            r_mede   <= 1'b0;
            r_ativo  <= 1'b0;
            r_erro   <= 1'b0;
            r_fim    <= 1'b0;
        end else begin
            r_mede <= 1'b0;
            r_erro <= 1'b0;
            r_fim  <= 1'b0;
            case (r_estado)
                INICIAL: begin
                    if (ligar) begin
                        r_estado <= POSICIONA;
                        r_ativo  <= 1'b1;
                    end else begin
                        r_ativo <= 1'b0;
                    end
                end
                POSICIONA: begin
                    if (w_fim) begin
                        r_estado <= MEDE;
                        r_mede   <= 1'b1;
                    end else begin
                        r_estado <= POSICIONA;
                    end
                end
                MEDE: r_estado <= ESPERA;
                ESPERA: begin
                    if (pronto_medida) begin
                        r_estado <= REGISTRA;
                    end else if (w_fim) begin
                        r_estado <= REGISTRA;
                        r_erro   <= 1'b1;
                    end else begin
                        r_estado <= ESPERA;
                    end
                end
                REGISTRA: r_estado <= PROXIMO;
                PROXIMO: begin
                    r_pos    <= w_pos_prox;
                    r_desce  <= w_desce_prox;
                    r_angulo <= angulo_bcd(w_pos_prox);
                    r_fim    <= w_vira;
                    if (ligar) begin
                        r_estado <= POSICIONA;
                    end else begin
                        r_estado <= INICIAL;
                        r_ativo  <= 1'b0;
                    end
                end
                default: begin
                    r_estado <= INICIAL;
                    r_ativo  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        dado_demux      = '0;
        dado_demux[2:0] = r_pos;
    end

    assign sel           = r_pos;
    assign mede          = r_mede;
    assign s_angulo      = r_angulo;
    assign ativo         = r_ativo;
    assign erro_timeout  = r_erro;
    assign fim_varredura = r_fim;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_controle_varredura_demux.sv
// Directed bench for controle_varredura_demux with SETTLE=4 and TIMEOUT=5.
module tb_controle_varredura_demux;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ligar = 1'b0;
    logic        pronto_medida = 1'b0;
    logic [2:0]  sel;
    logic [2:0]  dado_demux;
    logic        mede;
    logic [11:0] s_angulo;
    logic        ativo;
    logic        erro_timeout;
    logic        fim_varredura;
    logic [3:0]  db_estado;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] ang_tb [0:7] = '{12'h020, 12'h040, 12'h060, 12'h080,
                                  12'h100, 12'h120, 12'h140, 12'h160};
    int seq [0:16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};

    controle_varredura_demux #(
        .BITS(3), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(5)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .pronto_medida (pronto_medida),
        .sel           (sel),
        .dado_demux    (dado_demux),
        .mede          (mede),
        .s_angulo      (s_angulo),
        .ativo         (ativo),
        .erro_timeout  (erro_timeout),
        .fim_varredura (fim_varredura),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // From POSICIONA entry: mede rises on the fifth edge
    task automatic wait_mede(input int p);
        for (int j = 1; j <= 4; j++) begin
            tick();
            chk("mede_low_settle", 32'(mede), 32'd0);
        end
        tick();
        chk("mede_high", 32'(mede), 32'd1);
        chk("state_mede", 32'(db_estado), 32'd2);
        chk("sel_at_mede", 32'(sel), 32'(p));
    endtask

    // From the MEDE cycle: pronto 3 cycles later, end on next POSICIONA
    task automatic pos_cycle(input int p, input int p_next, input logic exp_fim);
        chk("dado_demux", 32'(dado_demux), 32'(p));
        chk("s_angulo", 32'(s_angulo), 32'(ang_tb[p]));
        tick();
        tick();
        tick();
        pronto_medida = 1'b1;
        tick();
        pronto_medida = 1'b0;
        chk("state_registra", 32'(db_estado), 32'd4);
        chk("no_timeout", 32'(erro_timeout), 32'd0);
        tick();
        chk("state_proximo", 32'(db_estado), 32'd5);
        chk("sel_stable", 32'(sel), 32'(p));
        tick();
        chk("state_posiciona", 32'(db_estado), 32'd1);
        chk("sel_next", 32'(sel), 32'(p_next));
        chk("fim_varredura", 32'(fim_varredura), 32'(exp_fim));
        chk("s_angulo_next", 32'(s_angulo), 32'(ang_tb[p_next]));
    endtask

    initial begin
        tick();
        tick();
        chk("rst_sel", 32'(sel), 32'd0);
        chk("rst_angulo", 32'(s_angulo), 32'h020);
        chk("rst_estado", 32'(db_estado), 32'd0);
        chk("rst_ativo", 32'(ativo), 32'd0);
        chk("rst_mede", 32'(mede), 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_estado", 32'(db_estado), 32'd0);

        // Start: mede 5 cycles after the ligar edge
        ligar = 1'b1;
        tick();
        chk("start_estado", 32'(db_estado), 32'd1);
        chk("start_ativo", 32'(ativo), 32'd1);
        wait_mede(0);
        chk("start_angulo", 32'(s_angulo), 32'h020);

        // Sixteen positions of the ping-pong walk
        for (int i = 0; i < 16; i++) begin
            if (i > 0) wait_mede(seq[i]);
            pos_cycle(seq[i], seq[i+1], (seq[i] == 7) || (seq[i] == 0 && i != 0));
        end

        // Timeout at pos 2: pulse 5 cycles after ESPERA entry
        wait_mede(2);
        for (int j = 1; j <= 5; j++) begin
            tick();
            chk("erro_low", 32'(erro_timeout), 32'd0);
        end
        tick();
        chk("erro_pulse", 32'(erro_timeout), 32'd1);
        chk("erro_estado", 32'(db_estado), 32'd4);
        tick();
        chk("erro_once", 32'(erro_timeout), 32'd0);
        tick();
        chk("timeout_sel", 32'(sel), 32'd3);

        // ligar dropped in POSICIONA at pos 3
        ligar = 1'b0;
        wait_mede(3);
        tick();
        tick();
        tick();
        pronto_medida = 1'b1;
        tick();
        pronto_medida = 1'b0;
        chk("stop_registra", 32'(db_estado), 32'd4);
        tick();
        chk("stop_ativo_prox", 32'(ativo), 32'd1);
        tick();
        chk("stop_estado", 32'(db_estado), 32'd0);
        chk("stop_ativo", 32'(ativo), 32'd0);
        chk("stop_sel", 32'(sel), 32'd4);
        chk("stop_angulo", 32'(s_angulo), 32'h100);
        tick();
        chk("stop_idle", 32'(db_estado), 32'd0);
        chk("stop_no_mede", 32'(mede), 32'd0);
        ligar = 1'b1;
        tick();
        chk("resume_estado", 32'(db_estado), 32'd1);
        chk("resume_sel", 32'(sel), 32'd4);

        // pronto on the exact expiry cycle at pos 4
        wait_mede(4);
        for (int j = 1; j <= 5; j++) tick();
        pronto_medida = 1'b1;
        tick();
        pronto_medida = 1'b0;
        chk("race_no_erro", 32'(erro_timeout), 32'd0);
        chk("race_estado", 32'(db_estado), 32'd4);
        tick();
        tick();
        chk("race_sel", 32'(sel), 32'd5);

        // Async reset during ESPERA at pos 5
        wait_mede(5);
        tick();
        tick();
        chk("pre_rst_estado", 32'(db_estado), 32'd3);
        #2;
        reset = 1'b1;
        ligar = 1'b0;
        #1;
        chk("arst_sel", 32'(sel), 32'd0);
        chk("arst_angulo", 32'(s_angulo), 32'h020);
        chk("arst_estado", 32'(db_estado), 32'd0);
        chk("arst_ativo", 32'(ativo), 32'd0);
        chk("arst_dado", 32'(dado_demux), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 32'(db_estado), 32'd0);
        ligar = 1'b1;
        tick();

        // pronto only during MEDE at pos 0: ignored, timeout follows
        wait_mede(0);
        pronto_medida = 1'b1;
        tick();
        pronto_medida = 1'b0;
        chk("mede_pronto_ignored", 32'(db_estado), 32'd3);
        for (int j = 2; j <= 5; j++) begin
            tick();
            chk("erro_low2", 32'(erro_timeout), 32'd0);
        end
        tick();
        chk("erro_pulse2", 32'(erro_timeout), 32'd1);
        tick();
        tick();
        chk("adv_sel", 32'(sel), 32'd1);
        chk("adv_no_fim", 32'(fim_varredura), 32'd0);
        chk("adv_angulo", 32'(s_angulo), 32'h040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
